imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the CPU core reads.
- Receives a framed byte stream over a valid/ready link, assembles little-endian 32-bit words and writes them to the imem write port starting at word address 0.
- Holds the CPU in reset (`cpu_reset`) until the image has been loaded and checksum-verified.

Parameters:
- ADDR_WIDTH, 8, imem word-address width; capacity is 2^ADDR_WIDTH words.
- WORD_WIDTH, 32, instruction width; fixed at 4 bytes per word.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a load.
- `rx_valid` in 1: byte available on `rx_data`.
- `rx_data` in 8: incoming byte.
- `rx_ready` out 1: loader can accept a byte; a byte transfers when `rx_valid && rx_ready` at `posedge clk`.
- `imem_we` out 1: imem write strobe, one cycle per word.
- `imem_waddr` out ADDR_WIDTH: imem word address.
- `imem_wdata` out WORD_WIDTH: imem write data.
- `cpu_reset` out 1: reset to the CPU core and PC.
- `busy` out 1: load in progress.
- `done` out 1: image loaded and checksum matched.
- `error` out 1: load failed.

Behaviour:
- Interface decision: one clock `clk`; `reset` is asynchronous and active-high.
- Frame format, in order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N×4 payload bytes, each word little-endian.
  - CSUM: 1 byte equal to the XOR of every preceding frame byte, including both length bytes.
- Reset values:
  - FSM = IDLE; `cpu_reset` = 1.
  - `rx_ready`, `imem_we`, `busy`, `done`, `error` = 0.
  - `imem_waddr` = 0; `imem_wdata` = 0.
  - Word counter, byte counter and running XOR = 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
  - IDLE: `rx_ready` = 0. On `start`, go to LEN_LO and clear the counters and XOR.
  - LEN_LO / LEN_HI: accept one byte each into N.
    - After LEN_HI, N == 0 or N > 2^ADDR_WIDTH goes to ERROR; no imem write occurs.
    - Otherwise go to DATA.
  - DATA:
    - A 2-bit byte counter shifts bytes into the word (first byte → bits [7:0]).
    - On the 4th accepted byte, the next cycle has `imem_we` = 1 for exactly one cycle, with `imem_waddr` = word index and `imem_wdata` = assembled word.
    - After the Nth word's 4th byte, go to CSUM. The final `imem_we` pulse occurs in the first CSUM cycle.
  - CSUM: accept one byte. If it equals the running XOR, go to DONE; otherwise go to ERROR.
  - DONE: `done` = 1, `cpu_reset` = 0.
  - ERROR: `error` = 1, `cpu_reset` = 1.
- `rx_ready` = 1 in LEN_LO, LEN_HI, DATA and CSUM, including during `imem_we` cycles; there is no back-pressure gap.
- `busy` = 1 in LEN_LO through CSUM.
- `cpu_reset` = 1 in every state except DONE.
- Registered outputs: all outputs are registered except `rx_ready`, which is decoded from the FSM state.
- `start` handling:
  - Ignored while `busy`.
  - In DONE or ERROR, `start` clears `done`/`error`, reasserts `cpu_reset` next cycle, and restarts at LEN_LO.
- `rx_valid` gaps of any length are tolerated; state holds.
- Writes never exceed address 2^ADDR_WIDTH−1, guaranteed by the N check.
- `reset` mid-load:
  - Immediately returns to IDLE with reset values.
  - Already-written imem words are left as-is.
  - `cpu_reset` stays 1 until a later successful load.

Decomposition:
- Package `loader_pkg`:
  - state enumeration;
  - constants LEN_BYTES = 2 and BYTES_PER_WORD = 4;
  - frame field ordering.
- Sub-module `byte_assembler`:
  - 4-byte little-endian shift/assemble register with byte counter;
  - `word_valid` pulse output;
  - clear input.
- The FSM, counters and XOR stay in `imem_loader`.

Test Plan:
1. Reset, then idle for 5 cycles → `cpu_reset` = 1; `rx_ready` = `imem_we` = `done` = `error` = 0; `imem_waddr` = 0.
2. `start`, then bytes 01 00 13 00 00 00 12 → one `imem_we`: addr 0, data 0x00000013; then `done` = 1, `cpu_reset` = 0, `busy` = 0.
3. `start`, then N = 2: bytes 02 00 | 93 00 10 00 | 73 00 10 00 | E2, with 3-cycle `rx_valid` gaps between bytes → writes addr 0 = 0x00100093, addr 1 = 0x00100073; then `done` = 1.
4. Same frame as scenario 2 but CSUM = 0x13 → `error` = 1, `done` = 0, `cpu_reset` = 1; addr 0 still written once.
5. Length bytes 00 00, and separately 01 01 (257 > 256) → ERROR immediately after LEN_HI; zero `imem_we` pulses. A following `start` plus a valid frame reaches DONE.
6. Assert `reset` after 6 payload bytes of a 2-word frame → only addr 0 written; FSM back to IDLE, `cpu_reset` = 1. A new `start` plus the full frame loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - loader FSM states, frame layout constants and helpers
package loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Frame fields in wire order: length (LE), payload words (LE), XOR checksum.
  typedef enum logic [1:0] {
    FLD_LEN_LO,
    FLD_LEN_HI,
    FLD_PAYLOAD,
    FLD_CSUM
  } field_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte receive link plus imem write port
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [WORD_WIDTH-1:0] imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - little-endian byte-to-word packer with one-cycle word pulse
module byte_assembler
  import loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        last_byte,
  output logic                        word_valid,
  output logic [BYTES_PER_WORD*8-1:0] word_data
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam int LOW_W = (BYTES_PER_WORD - 1) * 8;

  logic [CNT_W-1:0] byte_cnt;
  logic [LOW_W-1:0] low_bytes;

  assign last_byte = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      low_bytes  <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= '0;
      end else if (byte_valid) begin
        // Right shift so the first byte ends up in the least significant lane.
        low_bytes <= {byte_data, low_bytes[LOW_W-1:8]};
        byte_cnt  <= byte_cnt + 1'b1;
        if (last_byte) begin
          word_valid <= 1'b1;
          word_data  <= {byte_data, low_bytes};
        end
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a checksummed byte frame into imem, gating cpu_reset
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master link,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);
  localparam int LEN_W = LEN_BYTES * 8;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << ADDR_WIDTH;

  state_t                state, state_nx;
  logic [LEN_W-1:0]      len;
  logic [LEN_W-1:0]      word_cnt;
  logic [7:0]            xor_acc;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [LEN_W-1:0]      len_full;
  logic                  fire, load_start, len_bad, last_word, data_byte;
  logic                  asm_last, asm_valid;
  logic [BYTES_PER_WORD*8-1:0] asm_word;

  assign link.rx_ready = is_busy(state);
  assign fire          = link.rx_valid && link.rx_ready;
  assign load_start    = start && !is_busy(state);
  assign data_byte     = fire && (state == ST_DATA);
  assign len_full      = {link.rx_data, len[7:0]};
  assign len_bad       = (len_full == '0) || ({1'b0, len_full} > MAX_WORDS);
  assign last_word     = ((word_cnt + LEN_W'(1)) == len);

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_valid (data_byte),
    .byte_data  (link.rx_data),
    .last_byte  (asm_last),
    .word_valid (asm_valid),
    .word_data  (asm_word)
  );

  assign link.imem_we    = asm_valid;
  assign link.imem_waddr = waddr_q;
  assign link.imem_wdata = WORD_WIDTH'(asm_word);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (load_start) state_nx = ST_LEN_LO;
      ST_LEN_LO: if (fire) state_nx = ST_LEN_HI;
      ST_LEN_HI: if (fire) state_nx = len_bad ? ST_ERROR : ST_DATA;
      ST_DATA:   if (fire && asm_last && last_word) state_nx = ST_CSUM;
      ST_CSUM:   if (fire) state_nx = (link.rx_data == xor_acc) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR:  if (load_start) state_nx = ST_LEN_LO;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Status flags follow the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len       <= '0;
      word_cnt  <= '0;
      xor_acc   <= '0;
      waddr_q   <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      busy      <= is_busy(state_nx);
      done      <= (state_nx == ST_DONE);
      error     <= (state_nx == ST_ERROR);
      cpu_reset <= (state_nx != ST_DONE);
      if (load_start) begin
        len      <= '0;
        word_cnt <= '0;
        xor_acc  <= '0;
      end else if (fire) begin
        if (state != ST_CSUM) xor_acc <= xor_acc ^ link.rx_data;
        if (state == ST_LEN_LO) len[7:0]  <= link.rx_data;
        if (state == ST_LEN_HI) len[15:8] <= link.rx_data;
        if (data_byte && asm_last) begin
          word_cnt <= word_cnt + LEN_W'(1);
          waddr_q  <= word_cnt[ADDR_WIDTH-1:0];
        end
      end
    end
  end
endmodule
